// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    // Fetch side drives the request and consumes grant/response.
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    // Memory side.
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, one-entry
// hold buffer behind a stallable output slot, redirect with flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        bus,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_o,
    output logic                valid_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;

    // Redirect targets are forced word aligned; the low bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Request is a pure decode of the state register; address is the PC register.
    assign bus.imem_req_o  = (state == REQ);
    assign bus.imem_addr_o = pc_q;

    // Fetch FSM, PC, hold buffer and output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            instr_o    <= '0;
            pc_o       <= '0;
            valid_o    <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            // A consumed output empties unless something below reloads it.
            if (valid_o && !stall_i) begin
                valid_o <= 1'b0;
            end

            if (redirect_i) begin
                pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
                valid_o    <= 1'b0;
                hold_instr <= '0;
                hold_pc    <= '0;
                unique case (state)
                    REQ:     state <= bus.imem_gnt_i    ? DROP : REQ;
                    WAIT:    state <= bus.imem_rvalid_i ? REQ  : DROP;
                    DROP:    state <= bus.imem_rvalid_i ? REQ  : DROP;
                    default: state <= REQ;
                endcase
            end else begin
                unique case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (bus.imem_gnt_i) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rvalid_i) begin
                            pc_q <= pc_q + 32'd4;
                            if (!valid_o || !stall_i) begin
                                instr_o <= bus.imem_rdata_i;
                                pc_o    <= pc_q;
                                valid_o <= 1'b1;
                                state   <= REQ;
                            end else begin
                                hold_instr <= bus.imem_rdata_i;
                                hold_pc    <= pc_q;
                                state      <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            instr_o <= hold_instr;
                            pc_o    <= hold_pc;
                            valid_o <= 1'b1;
                            state   <= REQ;
                        end
                    end
                    DROP: begin
                        if (bus.imem_rvalid_i) begin
                            state <= REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage, the producer side of the decode stage's instruction input. It holds the PC, issues word fetches to instruction memory over a request/grant/response handshake, and presents instr_o/pc_o/valid_o to decode. It honours downstream stall and accepts PC redirects from execute, flushing in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address; word aligned
imem_gnt_i  input  1  memory accepted the request this cycle
imem_rvalid_i  input  1  read data valid
imem_rdata_i  input  32  instruction word
stall_i  input  1  decode cannot accept instr_o this cycle
redirect_i  input  1  load new PC, flush
redirect_pc_i  input  32  redirect target
instr_o  output  32  instruction to decode
pc_o  output  32  address of instr_o
valid_o  output  1  instr_o/pc_o valid

Behaviour:
- One clock, clk; reset asynchronous, active-low on rst_n. Reset: state IDLE, pc_q = RESET_PC, instr_o = 0, pc_o = 0, valid_o = 0, hold register = 0, imem_req_o = 0.
- imem_req_o = (state == REQ); imem_addr_o = pc_q. At most one outstanding request.
- States:
  - IDLE: entered only from reset; goes to REQ the next cycle.
  - REQ: on imem_gnt_i, go to WAIT.
  - WAIT: wait for imem_rvalid_i. On rvalid, if the output slot is free (!valid_o || !stall_i), load instr_o = rdata and pc_o = fetched address, set valid_o = 1, pc_q += 4, go to REQ. Otherwise store rdata in the hold register, pc_q += 4, go to HOLD.
  - HOLD: when !stall_i, move hold into instr_o/pc_o, set valid_o = 1, go to REQ.
  - DROP: an outstanding response must be discarded. On rvalid, ignore the data, go to REQ.
- Output slot:
  - While valid_o && stall_i, instr_o, pc_o and valid_o are held stable.
  - If valid_o && !stall_i and nothing new loads, valid_o drops to 0 the next cycle.
- Memory contract:
  - rvalid arrives at least 1 cycle after gnt.
  - Exactly one rvalid per gnt.
  - imem_addr_o may change while req is high and gnt is low.
- Redirect (redirect_i = 1) has highest priority:
  - pc_q = {redirect_pc_i[31:2], 2'b00}; valid_o = 0 next cycle; hold discarded.
  - From REQ without gnt: stay in REQ with the new address.
  - From REQ with gnt in the same cycle: go to DROP (the old address was granted).
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - From HOLD: go to REQ.
  - From DROP without rvalid: stay in DROP.
  - From DROP with rvalid: go to REQ.
  - From IDLE: go to REQ.
  - Redirect overrides stall.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Latency, no stalls, gnt immediate, rvalid 1 cycle after gnt:
  - req at cycle t, gnt at t, rvalid at t+1, valid_o at t+2, next req at t+2.
  - Throughput is 1 instruction per 2 cycles.
- Reset mid-operation: everything returns to reset values immediately. Any response still pending from memory after reset release is the memory's responsibility; memory is reset on the same rst_n.

Test Plan:
1. Reset release with RESET_PC = 0, memory granting immediately and returning 0x00500093, 0x00A00113 -> imem_addr_o sequence 0x0, 0x4, 0x8; instr_o = 0x00500093 with pc_o = 0x0, then 0x00A00113 with pc_o = 0x4; valid_o pulses each.
2. stall_i high for 5 cycles while valid_o = 1 and the next response arrives -> instr_o/pc_o unchanged across the stall; FSM in HOLD; after stall_i falls, next instr_o = held word at pc_o + 4; no word lost or duplicated.
3. redirect_i with redirect_pc_i = 0x200 while in WAIT; response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never appears on instr_o; next imem_addr_o = 0x200; valid_o = 0 until that word returns.
4. redirect_pc_i = 0x103 in the same cycle as gnt in REQ -> DROP entered; the subsequent fetch uses imem_addr_o = 0x100.
5. redirect to 0xFFFF_FFFC -> pc_o = 0xFFFF_FFFC, then the next imem_addr_o = 0x0000_0000.
6. rst_n asserted low while in HOLD with valid_o = 1 -> instr_o = 0, pc_o = 0, valid_o = 0, imem_req_o = 0 immediately; after release, the first imem_addr_o = RESET_PC.
